kong_edge_detector: RTL and testbench
=====================================

// Module: kong_edge_detector
// PURPOSE
//  Collision front-end for the Kong movement FSM: during each VGA frame it watches coincident
//  Kong/platform and Kong/rope drawing requests, classifies each hit pixel by which edge band of
//  Kong's bounding box it falls in, and publishes two edge vectors (indexed E_LEFT/E_TOP/E_RIGHT/
//  E_BOTTOM) once per frame. Sits between the per-object drawing blocks and the Kong controller.
// PARAMETERS
//  EDGE_BAND  4   width in pixels of each edge band measured inward from the box border
//  MIN_HITS   2   hit pixels needed in a frame for an edge bit to be reported (noise reject)
//  CNT_W      6   width of each per-edge hit counter; counters saturate at 2**CNT_W-1
// PORTS
//  clk                    in   1   system (pixel) clock
//  resetN                 in   1   asynchronous reset, active low
//  startOfFrame           in   1   1-cycle pulse at start of each VGA frame
//  pixelX, pixelY         in   11  current pixel coordinates (location, signed)
//  topLeftX, topLeftY     in   11  Kong bounding-box top-left corner (location)
//  kongDrawingRequest     in   1   Kong sprite opaque at current pixel
//  platformDrawingRequest in   1   a platform is drawn at current pixel
//  ropeDrawingRequest     in   1   a rope is drawn at current pixel
//  platformEdges          out  4   latched platform-contact edges, previous frame
//  ropeEdges              out  4   latched rope-contact edges, previous frame
//  edgesValid             out  1   1-cycle pulse when platformEdges/ropeEdges update
// BEHAVIOUR
//  Reset: clk single clock domain; resetN asynchronous active-low. platformEdges=0, ropeEdges=0,
//   edgesValid=0, all counters 0, FSM -> S_WAIT_SOF.
//  FSM: S_WAIT_SOF --startOfFrame--> S_ACCUM (no publish, no valid; counters cleared).
//   S_ACCUM --startOfFrame--> S_ACCUM with publish. A partial frame after reset is never published.
//  Hit classification (registered, 1-cycle pipeline): offX=pixelX-topLeftX, offY=pixelY-topLeftY,
//   both 11-bit signed. Pixel counts only if kongDrawingRequest && 0<=offX<KONG_WIDTH &&
//   0<=offY<KONG_HIGHT; otherwise ignored. Bands (may overlap; a corner pixel hits two):
//   LEFT offX<EDGE_BAND; RIGHT offX>=KONG_WIDTH-EDGE_BAND; TOP offY<EDGE_BAND;
//   BOTTOM offY>=KONG_HIGHT-EDGE_BAND. Interior pixels hit no edge.
//  Counting: 8 counters (4 platform, 4 rope); a classified hit increments the counter of each
//   matching band for each asserted target (platform and rope both may count same pixel).
//   Counters saturate, never wrap.
//  Publish on startOfFrame in S_ACCUM: edge bit = (counter >= MIN_HITS), registered into outputs
//   the cycle after startOfFrame, edgesValid high that same cycle for exactly 1 cycle.
//   Outputs hold between publishes. Counters clear at startOfFrame.
//  Pipeline alignment: the hit registered in the startOfFrame cycle belongs to the ending frame
//   (counted before publish); a raw hit presented in the startOfFrame cycle belongs to the new
//   frame and counts into the freshly cleared counters.
//  Two startOfFrame pulses with no hits -> outputs 0, edgesValid still pulses.
//  MIN_HITS=0 is illegal (assertion); MIN_HITS > 2**CNT_W-1 is illegal (assertion).
//  resetN asserted mid-frame: immediate clear, back to S_WAIT_SOF.
// STRUCTURE
//  kong_pkg: add typedef logic [3:0] edge_vector; reuse location, E_LEFT..E_BOTTOM,
//   KONG_WIDTH, KONG_HIGHT. Outputs typed edge_vector.
//  Sub-module kong_edge_counter: saturating CNT_W counter, inc/clear inputs, ge-threshold output;
//   8 instances (generate over edge index x target).
// TESTING
//  1 Reset, no startOfFrame -> outputs 0, edgesValid never pulses; first SOF -> still no pulse.
//  2 Kong at (100,200); 5 platform+kong pixels at y=263, x=110..114, then SOF -> platformEdges=
//    4'b0001 (BOTTOM), ropeEdges=0, edgesValid 1 cycle after SOF.
//  3 One kong+rope pixel at offset (0,0) only -> below MIN_HITS: ropeEdges=0; two such pixels ->
//    ropeEdges=4'b1100 (LEFT+TOP).
//  4 Kong+platform pixel at offset (16,32) (interior) x10 -> platformEdges=0; platform pixel
//    with kongDrawingRequest=0 -> ignored.
//  5 100 bottom hits (saturation at 63) -> BOTTOM reported, no wrap; next frame with 0 hits -> 0.
//  6 resetN low mid-frame after 10 hits -> outputs 0 at once; next SOF no pulse; following SOF
//    publishes only post-reset hits.

Source files
------------

// File: rtl/kong_pkg.sv
// Shared types and constants for the Kong sprite collision logic.
package kong_pkg;

    // Signed screen coordinate.
    typedef logic signed [10:0] location;

    // One bit per edge of Kong's bounding box.
    typedef logic [3:0] edge_vector;

    localparam int E_BOTTOM = 0;
    localparam int E_RIGHT  = 1;
    localparam int E_TOP    = 2;
    localparam int E_LEFT   = 3;

    // Kong bounding-box size in pixels.
    localparam int KONG_WIDTH = 32;
    localparam int KONG_HIGHT = 64;

    // Collision targets tracked per edge.
    localparam int N_TARGETS  = 2;
    localparam int T_PLATFORM = 0;
    localparam int T_ROPE     = 1;

    typedef enum logic [0:0] {
        S_WAIT_SOF,
        S_ACCUM
    } edge_state_e;

endpackage

// File: rtl/kong_edge_counter.sv
// Saturating hit counter with synchronous clear and a threshold compare.
// The compare includes the increment presented this cycle, so a clear and a
// final hit arriving together are still reflected in ge_o.
module kong_edge_counter
    import kong_pkg::*;
#(
    parameter int unsigned CNT_W    = 6,
    parameter int unsigned MIN_HITS = 2
) (
    input  logic clk,
    input  logic resetN,
    input  logic inc_i,
    input  logic clear_i,
    output logic ge_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] Thresh = CNT_W'(MIN_HITS);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    // Saturating increment, threshold compare and clear.
    always_comb begin
        cnt_inc = cnt_q;
        if (inc_i && (cnt_q != CntMax)) begin
            cnt_inc = cnt_q + CNT_W'(1);
        end
        ge_o  = (cnt_inc >= Thresh);
        cnt_d = clear_i ? '0 : cnt_inc;
    end

    // Counter state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/kong_edge_detector.sv
// Per-frame edge-contact detector for Kong against platforms and ropes.
// Classifies each Kong pixel that coincides with a target into edge bands,
// counts hits per edge and target, and publishes thresholded edge vectors
// once per frame.
module kong_edge_detector
    import kong_pkg::*;
#(
    parameter int unsigned EDGE_BAND = 4,
    parameter int unsigned MIN_HITS  = 2,
    parameter int unsigned CNT_W     = 6
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  location    pixelX,
    input  location    pixelY,
    input  location    topLeftX,
    input  location    topLeftY,
    input  logic       kongDrawingRequest,
    input  logic       platformDrawingRequest,
    input  logic       ropeDrawingRequest,
    output edge_vector platformEdges,
    output edge_vector ropeEdges,
    output logic       edgesValid
);

    localparam int unsigned CntMax = (1 << CNT_W) - 1;

    localparam location BoxW     = location'(KONG_WIDTH);
    localparam location BoxH     = location'(KONG_HIGHT);
    localparam location BandW    = location'(EDGE_BAND);
    localparam location RightLo  = location'(KONG_WIDTH - int'(EDGE_BAND));
    localparam location BottomLo = location'(KONG_HIGHT - int'(EDGE_BAND));

    location    off_x;
    location    off_y;
    logic       in_box;
    edge_vector bands;

    logic [N_TARGETS-1:0][3:0] hit_d;
    logic [N_TARGETS-1:0][3:0] hit_q;
    logic [N_TARGETS-1:0][3:0] ge;
    logic [N_TARGETS-1:0][3:0] edges_d;
    logic [N_TARGETS-1:0][3:0] edges_q;
    logic                      valid_d;
    logic                      valid_q;
    logic                      publish;

    edge_state_e state_q;
    edge_state_e state_d;

    // Classify the current pixel against Kong's box and its edge bands.
    always_comb begin
        off_x  = pixelX - topLeftX;
        off_y  = pixelY - topLeftY;
        in_box = kongDrawingRequest && !off_x[10] && (off_x < BoxW)
                 && !off_y[10] && (off_y < BoxH);
        bands           = '0;
        bands[E_LEFT]   = (off_x < BandW);
        bands[E_RIGHT]  = (off_x >= RightLo);
        bands[E_TOP]    = (off_y < BandW);
        bands[E_BOTTOM] = (off_y >= BottomLo);
        hit_d             = '0;
        hit_d[T_PLATFORM] = (in_box && platformDrawingRequest) ? bands : '0;
        hit_d[T_ROPE]     = (in_box && ropeDrawingRequest) ? bands : '0;
    end

    // One-cycle classification pipeline.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit_d;
        end
    end

    // One counter per edge and target; all clear at start of frame.
    for (genvar t = 0; t < N_TARGETS; t++) begin : gen_target
        for (genvar e = 0; e < 4; e++) begin : gen_edge
            kong_edge_counter #(
                .CNT_W    (CNT_W),
                .MIN_HITS (MIN_HITS)
            ) u_cnt (
                .clk     (clk),
                .resetN  (resetN),
                .inc_i   (hit_q[t][e]),
                .clear_i (startOfFrame),
                .ge_o    (ge[t][e])
            );
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_WAIT_SOF;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: the first frame start only arms accumulation.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_WAIT_SOF: if (startOfFrame) state_d = S_ACCUM;
            S_ACCUM:    state_d = S_ACCUM;
            default:    state_d = S_WAIT_SOF;
        endcase
    end

    // FSM outputs: publish the ending frame on each start of frame once armed.
    always_comb begin
        publish = (state_q == S_ACCUM) && startOfFrame;
        edges_d = publish ? ge : edges_q;
        valid_d = publish;
    end

    // Published edge vectors and valid pulse.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            edges_q <= '0;
            valid_q <= 1'b0;
        end else begin
            edges_q <= edges_d;
            valid_q <= valid_d;
        end
    end

    assign platformEdges = edges_q[T_PLATFORM];
    assign ropeEdges     = edges_q[T_ROPE];
    assign edgesValid    = valid_q;

    // A zero threshold or one the counter cannot reach makes the edges meaningless.
    param_ok_a: assert property (@(posedge clk) (MIN_HITS >= 1) && (MIN_HITS <= CntMax))
        else $error("kong_edge_detector: MIN_HITS out of range");

endmodule

// File: tb/tb_kong_edge_detector.sv
// Randomised and directed bench for kong_edge_detector with a scoreboard.
module tb_kong_edge_detector;
    import kong_pkg::*;

    localparam int MinHits = 2;
    localparam int SatMax  = 63;
    localparam int Band    = 4;

    typedef struct packed {
        logic [3:0] plat;
        logic [3:0] rope;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    location    pixelX, pixelY, topLeftX, topLeftY;
    logic       kongDrawingRequest, platformDrawingRequest, ropeDrawingRequest;
    edge_vector platformEdges, ropeEdges;
    logic       edgesValid;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    exp_t got_e;

    // Reference model state: hits per edge this frame, and whether a frame is open.
    int pc[4];
    int rc[4];
    bit armed;
    int tlx, tly;

    kong_edge_detector u_dut (
        .clk                    (clk),
        .resetN                 (resetN),
        .startOfFrame           (startOfFrame),
        .pixelX                 (pixelX),
        .pixelY                 (pixelY),
        .topLeftX               (topLeftX),
        .topLeftY               (topLeftY),
        .kongDrawingRequest     (kongDrawingRequest),
        .platformDrawingRequest (platformDrawingRequest),
        .ropeDrawingRequest     (ropeDrawingRequest),
        .platformEdges          (platformEdges),
        .ropeEdges              (ropeEdges),
        .edgesValid             (edgesValid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every valid pulse must match the oldest expected publish.
    always @(negedge clk) begin
        if (resetN && edgesValid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid cycle=%0d got plat=%b rope=%b, required no pulse",
                         cyc, platformEdges, ropeEdges);
            end else begin
                got_e = exp_q.pop_front();
                if (platformEdges !== got_e.plat || ropeEdges !== got_e.rope
                    || cyc != got_e.due) begin
                    errors++;
                    $display("FAIL publish cycle=%0d got plat=%b rope=%b, required plat=%b rope=%b at cycle %0d",
                             cyc, platformEdges, ropeEdges, got_e.plat, got_e.rope, got_e.due);
                end
            end
        end
    end

    task automatic check_now(input string name, input logic [3:0] got, input logic [3:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %b required %b", name, got, req);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) begin
            pc[i] = 0;
            rc[i] = 0;
        end
    endfunction

    // Spec rules at pixel level: box membership, edge bands, saturating counts.
    function automatic void model_pixel(input int px, input int py, input bit k,
                                        input bit p, input bit r);
        logic signed [10:0] ox, oy;
        bit hit[4];
        ox = 11'(px - tlx);
        oy = 11'(py - tly);
        if (!k || ox < 0 || ox >= KONG_WIDTH || oy < 0 || oy >= KONG_HIGHT) return;
        hit[3] = (ox < Band);
        hit[1] = (ox >= KONG_WIDTH - Band);
        hit[2] = (oy < Band);
        hit[0] = (oy >= KONG_HIGHT - Band);
        for (int i = 0; i < 4; i++) begin
            if (hit[i] && p) pc[i] = (pc[i] < SatMax) ? pc[i] + 1 : SatMax;
            if (hit[i] && r) rc[i] = (rc[i] < SatMax) ? rc[i] + 1 : SatMax;
        end
    endfunction

    // Drive one clock cycle of stimulus and update the model.
    task automatic step(input bit sof, input int px, input int py, input bit k,
                        input bit p, input bit r);
        exp_t e;
        startOfFrame           = sof;
        pixelX                 = 11'(px);
        pixelY                 = 11'(py);
        topLeftX               = 11'(tlx);
        topLeftY               = 11'(tly);
        kongDrawingRequest     = k;
        platformDrawingRequest = p;
        ropeDrawingRequest     = r;
        if (sof) begin
            if (armed) begin
                for (int i = 0; i < 4; i++) begin
                    e.plat[i] = (pc[i] >= MinHits);
                    e.rope[i] = (rc[i] >= MinHits);
                end
                e.due = cyc + 1;
                exp_q.push_back(e);
            end
            armed = 1'b1;
            model_clear();
        end
        model_pixel(px, py, k, p, r);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sof();
        step(1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        resetN = 1'b0;
        armed  = 1'b0;
        tlx    = 100;
        tly    = 200;
        model_clear();
        startOfFrame = 0; pixelX = 0; pixelY = 0; topLeftX = 0; topLeftY = 0;
        kongDrawingRequest = 0; platformDrawingRequest = 0; ropeDrawingRequest = 0;
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_plat", platformEdges, 4'b0000);
        check_now("reset_rope", ropeEdges, 4'b0000);
        check_now("reset_valid", {3'b000, edgesValid}, 4'b0000);
        resetN = 1'b1;

        // 1: idle without frame start, then the first frame start only arms.
        idle(6);
        sof();
        idle(3);
        check_now("first_sof_plat", platformEdges, 4'b0000);

        // 2: bottom row platform hits.
        for (int x = 110; x <= 114; x++) step(1'b0, x, 263, 1'b1, 1'b1, 1'b0);
        sof();
        idle(2);
        check_now("bottom_plat", platformEdges, 4'b0001);
        check_now("bottom_rope", ropeEdges, 4'b0000);

        // 3: rope at the top-left corner, once then twice.
        step(1'b0, 100, 200, 1'b1, 1'b0, 1'b1);
        sof();
        idle(2);
        check_now("corner_once_rope", ropeEdges, 4'b0000);
        step(1'b0, 100, 200, 1'b1, 1'b0, 1'b1);
        step(1'b0, 100, 200, 1'b1, 1'b0, 1'b1);
        sof();
        idle(2);
        check_now("corner_twice_rope", ropeEdges, 4'b1100);

        // 4: interior hits and platform without Kong are ignored.
        for (int i = 0; i < 10; i++) step(1'b0, 116, 232, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 100, 263, 1'b0, 1'b1, 1'b1);
        sof();
        idle(2);
        check_now("interior_plat", platformEdges, 4'b0000);
        check_now("interior_rope", ropeEdges, 4'b0000);

        // 5: saturation, then an empty frame.
        for (int i = 0; i < 100; i++) step(1'b0, 110, 263, 1'b1, 1'b1, 1'b0);
        sof();
        idle(2);
        check_now("saturate_plat", platformEdges, 4'b0001);
        idle(5);
        sof();
        idle(2);
        check_now("empty_frame_plat", platformEdges, 4'b0000);

        // 6: reset mid-frame.
        for (int i = 0; i < 10; i++) step(1'b0, 110, 263, 1'b1, 1'b1, 1'b0);
        resetN = 1'b0;
        armed  = 1'b0;
        model_clear();
        #1;
        check_now("midreset_plat", platformEdges, 4'b0000);
        check_now("midreset_rope", ropeEdges, 4'b0000);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 110, 263, 1'b1, 1'b1, 1'b0);
        sof();
        step(1'b0, 100, 200, 1'b1, 1'b0, 1'b1);
        step(1'b0, 101, 201, 1'b1, 1'b0, 1'b1);
        sof();
        idle(2);
        check_now("post_reset_plat", platformEdges, 4'b0000);
        check_now("post_reset_rope", ropeEdges, 4'b1100);

        // Random frames; hits may coincide with the frame start pulse.
        for (int f = 0; f < 150; f++) begin
            int len;
            tlx = $urandom_range(0, 1000);
            tly = $urandom_range(0, 900);
            len = $urandom_range(0, 60);
            for (int i = 0; i < len; i++) begin
                step(1'b0, tlx + $urandom_range(0, 40) - 4, tly + $urandom_range(0, 72) - 4,
                     ($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1));
            end
            step(1'b1, tlx + $urandom_range(0, 40) - 4, tly + $urandom_range(0, 72) - 4,
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1));
        end
        idle(4);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_publishes got %0d outstanding required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
